// File: rtl/modality_ngram_encoder.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// modality_ngram_encoder
//
// Fuses three per-modality spatial hypervectors by bitwise majority and forms
// a temporal N-gram over the last NGRAM_SIZE fused vectors:
//     G = H[0] ^ rho(H[1]) ^ rho^2(H[2]) ^ ... ^ rho^(N-1)(H[N-1])
// where H[0] is the newest fused vector and rho rotates toward higher bit
// indices. Vectors are declared [0:HV_DIMENSION-1] (bit 0 is the MSB).
// The registered N-gram goes downstream over a valid/ready handshake once
// the history window has been filled.
//
// Ports:
//   Clk_CI                 clock, rising edge
//   Reset_RBI              synchronous active-low reset
//   ValidIn_SI             three modality hypervectors present
//   ReadyOut_SO            block can accept a sample (Moore, gated by clear/reset)
//   HypervectorIn_mod1_DI  modality 1 spatial hypervector
//   HypervectorIn_mod2_DI  modality 2 spatial hypervector
//   HypervectorIn_mod3_DI  modality 3 spatial hypervector
//   ClearHistory_SI        drop N-gram history (honoured in IDLE only)
//   ValidOut_SO            N-gram hypervector valid
//   ReadyIn_SI             downstream accepts the N-gram
//   HypervectorOut_DO      registered N-gram hypervector
//------------------------------------------------------------------------------
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module modality_ngram_encoder #(
    parameter int HV_DIMENSION = `HV_DIMENSION,
    parameter int NGRAM_SIZE   = 3
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod1_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod2_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod3_DI,
    input  logic                    ClearHistory_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int                FILL_W    = $clog2(NGRAM_SIZE + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NGRAM_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [0:HV_DIMENSION-1]   hist_reg [NGRAM_SIZE];
    logic [FILL_W-1:0]         fill_reg;
    logic [0:HV_DIMENSION-1]   out_reg;
    logic                      valid_reg;

    logic [0:HV_DIMENSION-1]   fused;
    logic [0:HV_DIMENSION-1]   rotated   [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1]   xor_chain [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1]   ngram;

    // Bitwise majority of the three modalities.
    assign fused = (HypervectorIn_mod1_DI & HypervectorIn_mod2_DI)
                 | (HypervectorIn_mod1_DI & HypervectorIn_mod3_DI)
                 | (HypervectorIn_mod2_DI & HypervectorIn_mod3_DI);

    // History entry i is rotated by i positions toward higher indices. With
    // bit 0 as MSB, that is a numeric rotate-right of the packed vector.
    genvar gi;
    generate
        for (gi = 0; gi < NGRAM_SIZE; gi++) begin : g_rot
            localparam int ROT = gi % HV_DIMENSION;
            if (ROT == 0) begin : g_id
                assign rotated[gi] = hist_reg[gi];
            end else begin : g_shift
                assign rotated[gi] = (hist_reg[gi] >> ROT)
                                   | (hist_reg[gi] << (HV_DIMENSION - ROT));
            end
        end

        for (gi = 0; gi < NGRAM_SIZE; gi++) begin : g_xor
            if (gi == 0) begin : g_first
                assign xor_chain[gi] = rotated[gi];
            end else begin : g_rest
                assign xor_chain[gi] = xor_chain[gi-1] ^ rotated[gi];
            end
        end
    endgenerate

    assign ngram = xor_chain[NGRAM_SIZE-1];

    // Ready depends on state only, but a pending clear or an active reset
    // must keep the upstream from believing its sample was taken.
    assign ReadyOut_SO       = Reset_RBI && (state_reg == IDLE) && !ClearHistory_SI;
    assign ValidOut_SO       = valid_reg;
    assign HypervectorOut_DO = out_reg;

    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            state_reg <= IDLE;
            fill_reg  <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < NGRAM_SIZE; i++) begin
                hist_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ClearHistory_SI) begin
                        // Clear wins over a simultaneous sample.
                        fill_reg <= '0;
                        for (int i = 0; i < NGRAM_SIZE; i++) begin
                            hist_reg[i] <= '0;
                        end
                    end else if (ValidIn_SI) begin
                        hist_reg[0] <= fused;
                        for (int i = 1; i < NGRAM_SIZE; i++) begin
                            hist_reg[i] <= hist_reg[i-1];
                        end
                        if (fill_reg != FILL_FULL) begin
                            fill_reg <= fill_reg + FILL_W'(1);
                        end
                        state_reg <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    // Output register is refreshed even while the window is
                    // still filling; it is only flagged valid once full.
                    out_reg <= ngram;
                    if (fill_reg == FILL_FULL) begin
                        valid_reg <= 1'b1;
                        state_reg <= OUTPUT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                OUTPUT: begin
                    if (ReadyIn_SI) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modality_ngram_encoder.sv
`timescale 1ns/1ps
module tb_modality_ngram_encoder;

    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [0:D-1] m1, m2, m3;

    // NGRAM_SIZE = 3 instance
    logic         vin3, rdy_out3, clr3, vout3, rdy_in3;
    logic [0:D-1] hv3;
    // NGRAM_SIZE = 1 instance
    logic         vin1, rdy_out1, clr1, vout1, rdy_in1;
    logic [0:D-1] hv1;

    modality_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) dut3 (
        .Clk_CI                (clk),
        .Reset_RBI             (rst_n),
        .ValidIn_SI            (vin3),
        .ReadyOut_SO           (rdy_out3),
        .HypervectorIn_mod1_DI (m1),
        .HypervectorIn_mod2_DI (m2),
        .HypervectorIn_mod3_DI (m3),
        .ClearHistory_SI       (clr3),
        .ValidOut_SO           (vout3),
        .ReadyIn_SI            (rdy_in3),
        .HypervectorOut_DO     (hv3)
    );

    modality_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI                (clk),
        .Reset_RBI             (rst_n),
        .ValidIn_SI            (vin1),
        .ReadyOut_SO           (rdy_out1),
        .HypervectorIn_mod1_DI (m1),
        .HypervectorIn_mod2_DI (m2),
        .HypervectorIn_mod3_DI (m3),
        .ClearHistory_SI       (clr1),
        .ValidOut_SO           (vout1),
        .ReadyIn_SI            (rdy_in1),
        .HypervectorOut_DO     (hv1)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        check_cnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk8(input string name, input logic [0:D-1] act, input logic [0:D-1] exp);
        check_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // ---------------- reference model (NGRAM_SIZE = 3) ----------------
    logic [0:D-1] model_hist [3];
    int           model_fill;

    function automatic logic [0:D-1] ref_maj(input logic [0:D-1] a, b, c);
        logic [0:D-1] r;
        for (int k = 0; k < D; k++) r[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
        return r;
    endfunction

    function automatic logic [0:D-1] ref_rho(input logic [0:D-1] x, input int n);
        logic [0:D-1] r;
        for (int k = 0; k < D; k++) r[k] = x[(((k - n) % D) + D) % D];
        return r;
    endfunction

    function automatic logic [0:D-1] ref_ngram();
        logic [0:D-1] acc = '0;
        for (int i = 0; i < 3; i++) acc = acc ^ ref_rho(model_hist[i], i);
        return acc;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) model_hist[i] = '0;
        model_fill = 0;
    endfunction

    // One full sample through dut3; hold = cycles of backpressure in OUTPUT,
    // noisy = drive ValidIn with junk during the hold.
    task automatic sample3(input logic [0:D-1] a, b, c, input int hold, input bit noisy);
        logic [0:D-1] exp_g;
        logic         exp_v;
        m1 = a; m2 = b; m3 = c;
        vin3 = 1'b1;
        rdy_in3 = (hold == 0);
        #1;
        chk1("ready_before_accept", rdy_out3, 1'b1);
        @(posedge clk); #1;
        vin3 = 1'b0;
        model_hist[2] = model_hist[1];
        model_hist[1] = model_hist[0];
        model_hist[0] = ref_maj(a, b, c);
        if (model_fill < 3) model_fill++;
        chk1("ready_in_compute", rdy_out3, 1'b0);
        chk1("valid_in_compute", vout3, 1'b0);
        @(posedge clk); #1;
        exp_g = ref_ngram();
        exp_v = (model_fill == 3);
        chk1("valid_after_compute", vout3, exp_v);
        chk8("ngram_data", hv3, exp_g);
        if (exp_v) begin
            for (int h = 0; h < hold; h++) begin
                if (noisy) begin
                    vin3 = 1'b1;
                    m1 = D'($urandom); m2 = D'($urandom); m3 = D'($urandom);
                end
                @(posedge clk); #1;
                chk1("hold_valid", vout3, 1'b1);
                chk8("hold_data", hv3, exp_g);
                chk1("hold_ready", rdy_out3, 1'b0);
            end
            rdy_in3 = 1'b1;
            @(posedge clk); #1;
            vin3 = 1'b0;
            chk1("valid_after_transfer", vout3, 1'b0);
        end
        rdy_in3 = 1'b1;
        chk1("ready_back_in_idle", rdy_out3, 1'b1);
    endtask

    typedef struct {
        logic [0:D-1] a, b, c, exp;
    } maj_vec_t;

    maj_vec_t maj_tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        maj_tbl[0] = '{8'hF0, 8'hCC, 8'hAA, 8'hE8};
        maj_tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'h00};
        maj_tbl[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
        maj_tbl[3] = '{8'h0F, 8'h3C, 8'h55, 8'h1D};
        maj_tbl[4] = '{8'h12, 8'h34, 8'h56, 8'h16};
        maj_tbl[5] = '{8'h00, 8'h5A, 8'h5A, 8'h5A};

        rst_n = 1'b0;
        m1 = '0; m2 = '0; m3 = '0;
        vin3 = 1'b0; clr3 = 1'b0; rdy_in3 = 1'b1;
        vin1 = 1'b0; clr1 = 1'b0; rdy_in1 = 1'b1;
        model_clear();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_valid3", vout3, 1'b0);
        chk8("reset_data3", hv3, 8'h00);
        chk1("reset_ready3_forced_low", rdy_out3, 1'b0);
        chk1("reset_valid1", vout1, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("ready3_after_reset", rdy_out3, 1'b1);
        chk1("ready1_after_reset", rdy_out1, 1'b1);

        // ---- majority table, NGRAM_SIZE = 1 ----
        for (int t = 0; t < 6; t++) begin
            m1 = maj_tbl[t].a; m2 = maj_tbl[t].b; m3 = maj_tbl[t].c;
            vin1 = 1'b1;
            #1;
            chk1("n1_ready_before", rdy_out1, 1'b1);
            @(posedge clk); #1;
            vin1 = 1'b0;
            chk1("n1_no_valid_in_compute", vout1, 1'b0);
            @(posedge clk); #1;
            chk1("n1_valid", vout1, 1'b1);
            chk8("n1_majority", hv1, maj_tbl[t].exp);
            @(posedge clk); #1;
            chk1("n1_valid_one_cycle", vout1, 1'b0);
            chk1("n1_ready_after", rdy_out1, 1'b1);
        end

        // ---- N-gram fill, then backpressure on the first output ----
        sample3(8'hE8, 8'hE8, 8'hE8, 0, 1'b0);
        sample3(8'h01, 8'h01, 8'h01, 0, 1'b0);
        sample3(8'h00, 8'h00, 8'h00, 5, 1'b1);
        chk8("fill_ngram_BA", hv3, 8'hBA);

        // ---- sliding window: E8 drops out ----
        sample3(8'h00, 8'h00, 8'h00, 0, 1'b0);
        chk8("sliding_ngram_40", hv3, 8'h40);

        // ---- clear together with valid in IDLE with a full window ----
        clr3 = 1'b1; vin3 = 1'b1;
        m1 = 8'hFF; m2 = 8'hFF; m3 = 8'hFF;
        #1;
        chk1("clear_blocks_ready", rdy_out3, 1'b0);
        @(posedge clk); #1;
        clr3 = 1'b0; vin3 = 1'b0;
        model_clear();
        #1;
        chk1("clear_no_accept_ready", rdy_out3, 1'b1);
        chk1("clear_no_valid", vout3, 1'b0);
        for (int s = 0; s < 3; s++) sample3(D'($urandom), D'($urandom), D'($urandom), 0, 1'b0);

        // ---- reset while in OUTPUT ----
        m1 = 8'h3C; m2 = 8'hC3; m3 = 8'h3C;
        vin3 = 1'b1; rdy_in3 = 1'b0;
        @(posedge clk); #1;
        vin3 = 1'b0;
        @(posedge clk); #1;
        chk1("pre_reset_valid", vout3, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk1("midreset_valid", vout3, 1'b0);
        chk8("midreset_data", hv3, 8'h00);
        chk1("midreset_ready", rdy_out3, 1'b0);
        rst_n = 1'b1;
        rdy_in3 = 1'b1;
        model_clear();
        sample3(8'hA5, 8'hA5, 8'h00, 0, 1'b0);
        sample3(8'h5A, 8'h00, 8'h5A, 0, 1'b0);

        // ---- randomized traffic against the model ----
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                clr3 = 1'b1;
                vin3 = bit'($urandom_range(0, 1));
                #1;
                chk1("rand_clear_ready", rdy_out3, 1'b0);
                @(posedge clk); #1;
                clr3 = 1'b0; vin3 = 1'b0;
                model_clear();
            end
            sample3(D'($urandom), D'($urandom), D'($urandom),
                    int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/modality_ngram_encoder.md
# modality_ngram_encoder

Downstream stage of the three-modality spatial encoder. It accepts one spatial hypervector per modality for each sample and fuses them by bitwise majority. It then forms a temporal N-gram: the current fused vector XORed with progressively rotated copies of the previous NGRAM_SIZE-1 fused vectors. The registered N-gram is presented with a valid/ready handshake to the associative-memory / classification stage.

## Interface

Parameters:
- HV_DIMENSION, default `HV_DIMENSION (2000): hypervector width in bits; bit 0 is the MSB, vectors are declared [0:HV_DIMENSION-1].
- NGRAM_SIZE, default 3: N-gram length, legal range 1..8.

Ports:
- Clk_CI, input, 1: single clock; all state updates on rising edge.
- Reset_RBI, input, 1: synchronous, active-low reset.
- ValidIn_SI, input, 1: three modality hypervectors present.
- ReadyOut_SO, output, 1: block can accept a sample.
- HypervectorIn_mod1_DI / _mod2_DI / _mod3_DI, input, HV_DIMENSION each: per-modality spatial hypervectors.
- ClearHistory_SI, input, 1: discard the N-gram history (new trial/window).
- ValidOut_SO, output, 1: N-gram hypervector valid.
- ReadyIn_SI, input, 1: downstream accepts the N-gram.
- HypervectorOut_DO, output, HV_DIMENSION: registered N-gram hypervector.

## Operation

- Majority: M[k] = (m1[k]&m2[k]) | (m1[k]&m3[k]) | (m2[k]&m3[k]).
- Rotation rho: rho(x)[k] = x[(k-1) mod HV_DIMENSION]. Bit HV_DIMENSION-1 wraps to bit 0, i.e. a circular shift toward higher indices.
- History: NGRAM_SIZE-entry shift register H[0..N-1]; H[0] is newest. On accept, H[i] <= H[i-1] and H[0] <= M.
- Fill counter: 0..NGRAM_SIZE. Increments on each accept and saturates at NGRAM_SIZE.
- N-gram: G = H[0] ^ rho(H[1]) ^ rho²(H[2]) ^ ... ^ rho^(N-1)(H[N-1]). For NGRAM_SIZE=1, G = H[0].
- FSM states:
  - IDLE: ReadyOut_SO=1 unless ClearHistory_SI=1. If ClearHistory_SI=1: zero history and fill counter, accept nothing, stay in IDLE. Else if ValidIn_SI=1: accept the sample and go to COMPUTE.
  - COMPUTE: ReadyOut_SO=0. Load HypervectorOut_DO <= G. If the fill counter equals NGRAM_SIZE, go to OUTPUT; else go to IDLE (output register updated, ValidOut_SO stays 0).
  - OUTPUT: ValidOut_SO=1 and ReadyOut_SO=0. HypervectorOut_DO held stable. On ReadyIn_SI=1, go to IDLE.
- ClearHistory_SI is ignored outside IDLE.
- The output register changes only in COMPUTE.

## Timing

- Reset (Reset_RBI=0 at a clock edge):
  - state=IDLE, history=0, fill=0, HypervectorOut_DO=0, ValidOut_SO=0.
  - ReadyOut_SO is forced 0 while Reset_RBI=0.
- Reset dominates every state. Asserting it in COMPUTE or OUTPUT drops ValidOut_SO after that edge and discards history.
- Latency: a sample accepted at edge E0 gives ValidOut_SO=1 after E1, provided the window is full.
- Throughput: at most one sample per 3 cycles with ReadyIn_SI tied high (accept, COMPUTE, OUTPUT). With the window not yet full, one per 2 cycles.
- Handshake: a transfer occurs on an edge with ValidOut_SO & ReadyIn_SI.
  - ValidOut_SO never drops without a transfer, except on reset.
  - Data is stable while ValidOut_SO=1.
- ReadyOut_SO is a Moore output (state only), gated combinationally by ClearHistory_SI and Reset_RBI.
- ValidIn_SI together with ClearHistory_SI in IDLE: clear wins and the sample is not accepted (ReadyOut_SO=0).
- Fill counter saturation: once full, every subsequent accept produces an output; the oldest entry falls out.

## Test plan

Bench uses HV_DIMENSION=8; values in hex, bit 0 = MSB.

- **Majority, NGRAM_SIZE=1:** mod1=F0, mod2=CC, mod3=AA, ValidIn for 1 cycle, ReadyIn=1.
  - Expect ValidOut_SO=1 for exactly 1 cycle, beginning the second edge after accept, HypervectorOut_DO=E8.
- **N-gram fill, NGRAM_SIZE=3:** samples with all mods equal: E8, then 01, then 00.
  - Expect no ValidOut after the first two samples.
  - After the third, HypervectorOut_DO=BA (rho²(E8)=3A, rho(01)=80, 3A^80^00=BA).
- **Backpressure:** in OUTPUT, hold ReadyIn_SI=0 for 5 cycles.
  - Expect ValidOut_SO=1 and data constant, ReadyOut_SO=0 throughout, ValidIn ignored.
  - Transfer on the first cycle ReadyIn=1; ReadyOut_SO=1 in the following cycle.
- **Clear vs. valid:** in IDLE with a full window, assert ClearHistory_SI and ValidIn_SI together.
  - Expect ReadyOut_SO=0 and no accept.
  - The next three samples give valid output only on the third.
- **Reset mid-operation:** drive Reset_RBI=0 for 1 cycle while in OUTPUT.
  - Expect ValidOut_SO=0 and HypervectorOut_DO=00 after that edge.
  - The next two samples produce no output (NGRAM_SIZE=3).
- **Sliding window:** after fill, feed a 4th sample 00.
  - Expect output rho²(01) ^ rho(00) ^ 00 = 40, with E8 shifted out.
